// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   WIDTH-bit binary adder built from a ripple chain of 1-bit full-adder cells.
//   It produces the sum, the carry out of the MSB and a signed-overflow flag.
//   With REGISTERED=1 the result is captured on clk with one cycle of latency.
//   With REGISTERED=0 the outputs follow the inputs combinationally.
//
// Parameters
//   WIDTH      operand width in bits, 1..64
//   REGISTERED 1: outputs registered (1-cycle latency); 0: combinational
//
// Ports
//   clk        in   1      rising-edge clock (unused when REGISTERED=0)
//   rst        in   1      synchronous active-high reset (unused when REGISTERED=0)
//   a          in   WIDTH  operand A (unsigned, or two's complement for ovf)
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in, added at bit 0
//   in_valid   in   1      operands valid this cycle
//   sum        out  WIDTH  (a + b + cin) mod 2^WIDTH
//   cout       out  1      bit WIDTH of a + b + cin
//   ovf        out  1      signed overflow: carry into MSB xor carry out of MSB
//   out_valid  out  1      sum/cout/ovf hold a fresh result
//
// Handshake: valid-only and without backpressure. An operand set is consumed
// on every edge where in_valid=1. out_valid pulses for exactly one cycle per
// consumed operand set. When out_valid=0, the result outputs keep the last
// result.
// -----------------------------------------------------------------------------
module full_adder #(
    parameter int WIDTH      = 1,
    parameter bit REGISTERED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic             ovf_c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    // When WIDTH=1, c[WIDTH-1] is cin, so this reduces to cin ^ cout.
    assign ovf_c = c[WIDTH-1] ^ c[WIDTH];

    if (REGISTERED) begin : g_reg
        always_ff @(posedge clk) begin
            if (rst) begin
                sum       <= '0;
                cout      <= 1'b0;
                ovf       <= 1'b0;
                out_valid <= 1'b0;
            end else if (in_valid) begin
                sum       <= s;
                cout      <= c[WIDTH];
                ovf       <= ovf_c;
                out_valid <= 1'b1;
            end else begin
                // When idle, the result is held so that inputs changing
                // while invalid (including X) never reach the outputs.
                out_valid <= 1'b0;
            end
        end
    end else begin : g_comb
        // clk and rst play no part in the combinational configuration.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

        assign sum       = s;
        assign cout      = c[WIDTH];
        assign ovf       = ovf_c;
        assign out_valid = in_valid;
    end

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
//   Drives four full_adder configurations from one clock and one reset:
//     u_w1  : WIDTH=1,  registered
//     u_w4  : WIDTH=4,  registered
//     u_w16 : WIDTH=16, registered (random stream, expected-result queue)
//     u_w8c : WIDTH=8,  combinational
//   A reference model computes each result with integer arithmetic. Signed
//   overflow is found by range-checking the signed sum. A single negedge
//   process compares every instance against the model on every cycle. Directed
//   sections add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_full_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        a1, b1, c1, v1;
    logic        s1, co1, ov1, ovld1;
    logic [3:0]  a4, b4, s4;
    logic        c4, v4, co4, ov4, ovld4;
    logic [15:0] a16, b16, s16;
    logic        c16, v16, co16, ov16, ovld16;
    logic [7:0]  a8, b8, s8;
    logic        c8, v8, co8, ov8, ovld8;

    full_adder #(.WIDTH(1), .REGISTERED(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(c1), .in_valid(v1),
        .sum(s1), .cout(co1), .ovf(ov1), .out_valid(ovld1));

    full_adder #(.WIDTH(4), .REGISTERED(1'b1)) u_w4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(c4), .in_valid(v4),
        .sum(s4), .cout(co4), .ovf(ov4), .out_valid(ovld4));

    full_adder #(.WIDTH(16), .REGISTERED(1'b1)) u_w16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(c16), .in_valid(v16),
        .sum(s16), .cout(co16), .ovf(ov16), .out_valid(ovld16));

    full_adder #(.WIDTH(8), .REGISTERED(1'b0)) u_w8c (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(c8), .in_valid(v8),
        .sum(s8), .cout(co8), .ovf(ov8), .out_valid(ovld8));

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // The arithmetic is done on integers. Overflow means the true signed sum
    // falls outside the w-bit two's-complement range.
    function automatic void ref_add(input int w, input longint unsigned a,
                                    input longint unsigned b, input bit cin,
                                    output longint unsigned s, output bit co,
                                    output bit ov);
        longint unsigned full;
        longint          sa, sb, ss, lim;
        full = a + b + longint'(cin);
        s    = full & ((64'd1 << w) - 64'd1);
        co   = full[w];
        lim  = longint'(64'd1 << (w - 1));
        sa   = (a >= longint'(lim)) ? longint'(a) - 2 * lim : longint'(a);
        sb   = (b >= longint'(lim)) ? longint'(b) - 2 * lim : longint'(b);
        ss   = sa + sb + longint'(cin);
        ov   = (ss > lim - 1) || (ss < -lim);
    endfunction

    // Model state for the registered instances.
    bit              m_known = 1'b0;
    longint unsigned m1_s, m4_s;
    bit              m1_co, m1_ov, m1_v, m4_co, m4_ov, m4_v;
    bit              ev16;
    logic [17:0]     exp_q[$];

    always @(posedge clk) begin
        longint unsigned t_s;
        bit              t_co, t_ov;
        if (rst) begin
            m_known = 1'b1;
            m1_s = 0; m1_co = 0; m1_ov = 0; m1_v = 0;
            m4_s = 0; m4_co = 0; m4_ov = 0; m4_v = 0;
            ev16 = 1'b0;
            exp_q.delete();
        end else begin
            if (v1) begin ref_add(1, longint'(a1), longint'(b1), c1, m1_s, m1_co, m1_ov); m1_v = 1; end
            else m1_v = 0;
            if (v4) begin ref_add(4, longint'(a4), longint'(b4), c4, m4_s, m4_co, m4_ov); m4_v = 1; end
            else m4_v = 0;
            if (v16) begin
                ref_add(16, longint'(a16), longint'(b16), c16, t_s, t_co, t_ov);
                exp_q.push_back({t_ov, t_co, t_s[15:0]});
                ev16 = 1'b1;
            end else ev16 = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        longint unsigned t_s;
        bit              t_co, t_ov;
        logic [17:0]     e;
        ref_add(8, longint'(a8), longint'(b8), c8, t_s, t_co, t_ov);
        check("w8c_sum",   longint'(s8),    t_s);
        check("w8c_cout",  longint'(co8),   longint'(t_co));
        check("w8c_ovf",   longint'(ov8),   longint'(t_ov));
        check("w8c_valid", longint'(ovld8), longint'(v8));
        if (m_known) begin
            check("w1_sum",   longint'(s1),    m1_s);
            check("w1_cout",  longint'(co1),   longint'(m1_co));
            check("w1_ovf",   longint'(ov1),   longint'(m1_ov));
            check("w1_valid", longint'(ovld1), longint'(m1_v));
            check("w4_sum",   longint'(s4),    m4_s);
            check("w4_cout",  longint'(co4),   longint'(m4_co));
            check("w4_ovf",   longint'(ov4),   longint'(m4_ov));
            check("w4_valid", longint'(ovld4), longint'(m4_v));
            check("w16_valid", longint'(ovld16), longint'(ev16));
            if (ovld16 && ev16 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("w16_result", longint'({ov16, co16, s16}), longint'(e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input bit a, input bit b, input bit c, input bit v);
        a1 = a; b1 = b; c1 = c; v1 = v;
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input bit c, input bit v);
        a4 = a; b4 = b; c4 = c; v4 = v;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]  sum_tt, cout_tt;
        logic [2:0]  idx;
        int          accepted;
        int          cyc;

        drive1(0, 0, 0, 0);
        drive4('0, '0, 0, 0);
        a16 = '0; b16 = '0; c16 = 0; v16 = 0;
        a8 = '0; b8 = '0; c8 = 0; v8 = 0;
        rst = 1'b1;
        step();
        step();
        // Reset state
        check("rst_w1_sum",   longint'(s1),    0);
        check("rst_w1_valid", longint'(ovld1), 0);
        check("rst_w4_cout",  longint'(co4),   0);
        rst = 1'b0;

        // T1: WIDTH=1 truth table, one combination per cycle, literal table
        sum_tt  = 8'b1001_0110;
        cout_tt = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            drive1(idx[2], idx[1], idx[0], 1);
            step();
            check("t1_sum",   longint'(s1),    longint'(sum_tt[idx]));
            check("t1_cout",  longint'(co1),   longint'(cout_tt[idx]));
            check("t1_valid", longint'(ovld1), 1);
        end

        // T2: reset mid-stream, then 1,1,0 -> sum=0 cout=1
        drive1(1, 1, 1, 1);
        rst = 1'b1;
        step();
        check("t2_rst_sum",   longint'(s1),    0);
        check("t2_rst_cout",  longint'(co1),   0);
        check("t2_rst_ovf",   longint'(ov1),   0);
        check("t2_rst_valid", longint'(ovld1), 0);
        rst = 1'b0;
        drive1(1, 1, 0, 1);
        step();
        check("t2_sum",  longint'(s1),  0);
        check("t2_cout", longint'(co1), 1);

        // T3: hold while idle with ones on the inputs
        drive1(1, 0, 0, 1);
        step();
        check("t3_load_sum", longint'(s1), 1);
        drive1(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_hold_sum",   longint'(s1),    1);
            check("t3_hold_cout",  longint'(co1),   0);
            check("t3_hold_valid", longint'(ovld1), 0);
        end
        drive1(0, 0, 0, 0);

        // T4: WIDTH=4 boundaries
        drive4(4'hF, 4'h0, 1, 1);
        step();
        check("t4a_sum",  longint'(s4),  0);
        check("t4a_cout", longint'(co4), 1);
        check("t4a_ovf",  longint'(ov4), 0);
        drive4(4'h7, 4'h1, 0, 1);
        step();
        check("t4b_sum",  longint'(s4),  8);
        check("t4b_cout", longint'(co4), 0);
        check("t4b_ovf",  longint'(ov4), 1);
        drive4(4'hF, 4'hF, 1, 1);
        step();
        check("t4c_sum",  longint'(s4),  15);
        check("t4c_cout", longint'(co4), 1);
        drive4(4'h0, 4'h0, 0, 1);
        step();
        check("t4d_sum",  longint'({co4, ov4, s4}), 0);
        drive4('0, '0, 0, 0);

        // T5: combinational WIDTH=8, reset has no effect
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1; v8 = 1;
        #1;
        check("t5_sum",   longint'(s8),    255);
        check("t5_cout",  longint'(co8),   1);
        check("t5_ovf",   longint'(ov8),   0);
        check("t5_valid", longint'(ovld8), 1);
        rst = 1'b1;
        step();
        check("t5_rst_sum",  longint'(s8),  255);
        check("t5_rst_cout", longint'(co8), 1);
        rst = 1'b0;
        step();
        a8 = 8'h7F; b8 = 8'h00; c8 = 1;
        #1;
        check("t5_ovf_pos", longint'(ov8), 1);

        // T6: random stream; 10000 accepted WIDTH=16 vectors plus random traffic elsewhere
        accepted = 0;
        cyc = 0;
        while (accepted < 10000 && cyc < 40000) begin
            rst = ($urandom_range(0, 299) == 0);
            v16 = ($urandom_range(0, 3) != 0);
            if (accepted == 0) begin
                a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1; v16 = 1;
            end else if (accepted == 1) begin
                a16 = 16'h0000; b16 = 16'h0000; c16 = 0; v16 = 1;
            end else if (v16) begin
                a16 = 16'($urandom_range(0, 65535));
                b16 = 16'($urandom_range(0, 65535));
                c16 = 1'($urandom_range(0, 1));
            end else begin
                a16 = 'x; b16 = 'x; c16 = 1'bx;
            end
            drive1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drive4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            c8 = 1'($urandom_range(0, 1));
            v8 = 1'($urandom_range(0, 1));
            if (v16 && !rst) accepted++;
            cyc++;
            step();
        end
        check("t6_accepted", longint'(accepted), 10000);

        rst = 1'b0;
        v16 = 0; drive1(0, 0, 0, 0); drive4('0, '0, 0, 0);
        step();
        step();
        check("t6_drain", longint'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
